// File: rtl/cpu_bus_fabric.sv
// CPU bus fabric: address decode, wait-state and timeout stall control,
// registered read-data mux and a small IRQ/error control register block.
module cpu_bus_fabric #(
    parameter int unsigned          NSLV     = 8,
    parameter int unsigned          AW       = 16,
    parameter int unsigned          DW       = 8,
    parameter logic [NSLV*AW-1:0]   SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0]   SLV_MASK = '0,
    parameter logic [NSLV*3-1:0]    SLV_WAIT = '0,
    parameter logic [AW-1:0]        CTL_BASE = AW'(16'hF700),
    parameter logic [AW-1:0]        CTL_MASK = AW'(16'hFFFC),
    parameter logic [7:0]           TO_CYC   = 8'd255,
    parameter logic [DW-1:0]        DEF_DATA = DW'(8'hFF)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AW-1:0]       cpu_ab,
    input  logic                cpu_we,
    input  logic [DW-1:0]       cpu_do,
    output logic [DW-1:0]       cpu_di,
    output logic                cpu_rdy,
    output logic                cpu_irq,
    output logic [NSLV-1:0]     slv_sel,
    input  logic [NSLV-1:0]     slv_rdy,
    input  logic [NSLV*DW-1:0]  slv_do,
    input  logic [NSLV-1:0]     slv_irq
);

    localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;

    logic            ctl_hit;
    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic            unmapped;
    logic [2:0]      wait_n;
    logic            raw_rdy;
    logic            timeout;
    logic [2:0]      ws_nxt;
    logic            ctl_wr;
    logic [1:0]      err_nxt;
    logic [1:0]      err_clr;
    logic [DW-1:0]   ctl_data;

    logic            rdy_q;
    logic [2:0]      ws_cnt;
    logic [7:0]      to_cnt;
    logic [IW-1:0]   sel_idx;
    logic            sel_ctl;
    logic            sel_unm;
    logic [1:0]      sel_reg;
    logic [NSLV-1:0] irq_mask;
    logic [1:0]      err;
    logic [IW-1:0]   err_idx;

    // Address decode: control region wins, then the lowest matching slot.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        ctl_hit = ((cpu_ab & CTL_MASK) == CTL_BASE);
        for (int i = int'(NSLV) - 1; i >= 0; i--) begin
            if ((cpu_ab & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        if (ctl_hit) begin
            hit = 1'b0;
        end
        unmapped = !ctl_hit && !hit;
        slv_sel  = hit ? (NSLV'(1'b1) << hit_idx) : '0;
        wait_n   = SLV_WAIT[32'(hit_idx)*3 +: 3];
    end

    // Stall control: a fresh access to a wait-state slot stalls WAIT cycles
    // before the slave's own ready is honoured; timeout overrides everything.
    always_comb begin
        raw_rdy = 1'b1;
        ws_nxt  = ws_cnt;
        if (hit) begin
            if (wait_n == 3'd0) begin
                raw_rdy = slv_rdy[hit_idx];
            end else if (rdy_q) begin
                raw_rdy = 1'b0;
                ws_nxt  = wait_n - 3'd1;
            end else if (ws_cnt != 3'd0) begin
                raw_rdy = 1'b0;
                ws_nxt  = ws_cnt - 3'd1;
            end else begin
                raw_rdy = slv_rdy[hit_idx];
            end
        end
        timeout = !raw_rdy && (to_cnt == (TO_CYC - 8'd1));
        cpu_rdy = raw_rdy || timeout;
        if (cpu_rdy) begin
            ws_nxt = '0;
        end
    end

    // Error register: write-1-clear loses to a coincident set of the same bit.
    always_comb begin
        ctl_wr  = ctl_hit && cpu_we;
        err_clr = (ctl_wr && (cpu_ab[1:0] == 2'd2)) ? cpu_do[1:0] : 2'b00;
        err_nxt = (err & ~err_clr) | {timeout, unmapped};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q    <= 1'b1;
            ws_cnt   <= '0;
            to_cnt   <= '0;
            sel_idx  <= '0;
            sel_ctl  <= 1'b0;
            sel_unm  <= 1'b1;
            sel_reg  <= '0;
            irq_mask <= '1;
            err      <= '0;
            err_idx  <= '0;
        end else begin
            rdy_q  <= cpu_rdy;
            ws_cnt <= ws_nxt;
            to_cnt <= cpu_rdy ? 8'd0 : (to_cnt + 8'd1);
            if (cpu_rdy) begin
                sel_idx <= hit_idx;
                sel_ctl <= ctl_hit;
                sel_unm <= unmapped;
                sel_reg <= cpu_ab[1:0];
            end
            if (ctl_wr && (cpu_ab[1:0] == 2'd0)) begin
                irq_mask <= cpu_do[NSLV-1:0];
            end
            err <= err_nxt;
            if (timeout) begin
                err_idx <= hit_idx;
            end
        end
    end

    // Read data follows the select captured on the last ready cycle.
    always_comb begin
        case (sel_reg)
            2'd0:    ctl_data = DW'(irq_mask);
            2'd1:    ctl_data = DW'(slv_irq & irq_mask);
            2'd2:    ctl_data = DW'(err);
            default: ctl_data = DW'(err_idx);
        endcase
        if (sel_ctl) begin
            cpu_di = ctl_data;
        end else if (sel_unm) begin
            cpu_di = DEF_DATA;
        end else begin
            cpu_di = slv_do[32'(sel_idx)*DW +: DW];
        end
    end

    assign cpu_irq = |(slv_irq & irq_mask);

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Directed plus randomized checks of cpu_bus_fabric against an address-range
// reference model of the memory map, stall lengths and control registers.
module tb_cpu_bus_fabric;

    localparam logic [8*16-1:0] BASE = {16'hF000, 16'h4000, 16'h5000, 16'h4000,
                                        16'h3000, 16'h2000, 16'h1000, 16'h0000};
    localparam logic [8*16-1:0] MASK = {16'hF000, 16'hC000, 16'hF000, 16'hF000,
                                        16'hF000, 16'hF000, 16'hF000, 16'hF000};
    localparam logic [8*3-1:0]  WAIT = {3'd5, 3'd0, 3'd2, 3'd1, 3'd7, 3'd3, 3'd0, 3'd0};

    // Reference map as inclusive address ranges, searched lowest slot first.
    localparam logic [15:0] LO [8] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000,
                                       16'h4000, 16'h5000, 16'h4000, 16'hF000};
    localparam logic [15:0] HI [8] = '{16'h0FFF, 16'h1FFF, 16'h2FFF, 16'h3FFF,
                                       16'h4FFF, 16'h5FFF, 16'h7FFF, 16'hFFFF};
    localparam int          WT [8] = '{0, 0, 3, 7, 1, 2, 0, 5};

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic        cpu_we;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        cpu_irq;
    logic [7:0]  slv_sel;
    logic [7:0]  slv_rdy;
    logic [63:0] slv_do;
    logic [7:0]  slv_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] m_mask;
    logic [1:0] m_err;
    logic [2:0] m_idx;

    cpu_bus_fabric #(
        .NSLV(8), .AW(16), .DW(8),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .SLV_WAIT(WAIT),
        .CTL_BASE(16'hF700), .CTL_MASK(16'hFFFC),
        .TO_CYC(8'd255), .DEF_DATA(8'hFF)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
        .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .cpu_irq(cpu_irq),
        .slv_sel(slv_sel), .slv_rdy(slv_rdy), .slv_do(slv_do), .slv_irq(slv_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus access: returns stall count and slv_sel seen; ends 1 ns after the ready edge.
    task automatic access(input logic [15:0] a, input logic we, input logic [7:0] d,
                          output int stalls, output logic [7:0] sel);
        cpu_ab = a;
        cpu_we = we;
        cpu_do = d;
        stalls = 0;
        @(negedge clk);
        sel = slv_sel;
        while (!cpu_rdy && stalls < 400) begin
            stalls++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        cpu_ab = 16'h0000;
    endtask

    function automatic int ref_slot(input logic [15:0] a);
        if (a >= 16'hF700 && a <= 16'hF703) return -2;
        for (int i = 0; i < 8; i++) begin
            if (a >= LO[i] && a <= HI[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] ref_ctl(input logic [1:0] r);
        case (r)
            2'd0:    return m_mask;
            2'd1:    return slv_irq & m_mask;
            2'd2:    return {6'b0, m_err};
            default: return {5'b0, m_idx};
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         st;
        logic [7:0] sl;

        reset   = 1'b1;
        cpu_ab  = 16'h0000;
        cpu_we  = 1'b0;
        cpu_do  = 8'h00;
        slv_rdy = 8'hFF;
        slv_do  = 64'h0;
        slv_irq = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_rdy", 32'(cpu_rdy), 32'd1);
        chk("reset_di_unmapped", 32'(cpu_di), 32'hFF);
        chk("reset_sel", 32'(slv_sel), 32'h01);
        chk("reset_irq", 32'(cpu_irq), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Slot 0, no wait states
        slv_do[7:0] = 8'h5A;
        access(16'h0010, 1'b0, 8'h00, st, sl);
        chk("s0_sel", 32'(sl), 32'h01);
        chk("s0_stall", 32'(st), 32'd0);
        chk("s0_data", 32'(cpu_di), 32'h5A);

        // Slot 2, three wait states; read mux must hold the old select while stalled
        slv_do[23:16] = 8'hC3;
        cpu_ab = 16'h2345;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s2_stall_rdy", 32'(cpu_rdy), 32'd0);
            chk("s2_hold_di", 32'(cpu_di), 32'h5A);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("s2_ready", 32'(cpu_rdy), 32'd1);
        @(posedge clk);
        #1;
        chk("s2_data", 32'(cpu_di), 32'hC3);
        cpu_ab = 16'h0000;

        // Unmapped access, error flag and write-1-clear
        access(16'h9000, 1'b0, 8'h00, st, sl);
        chk("unm_sel", 32'(sl), 32'h00);
        chk("unm_stall", 32'(st), 32'd0);
        chk("unm_data", 32'(cpu_di), 32'hFF);
        access(16'hF702, 1'b0, 8'h00, st, sl);
        chk("err_unm", 32'(cpu_di), 32'h01);
        access(16'hF702, 1'b1, 8'h01, st, sl);
        access(16'hF702, 1'b0, 8'h00, st, sl);
        chk("err_clr0", 32'(cpu_di), 32'h00);

        // Decode priority: control over slot 7, lowest slot on overlap
        access(16'hF701, 1'b0, 8'h00, st, sl);
        chk("prio_ctl_sel", 32'(sl), 32'h00);
        access(16'h4800, 1'b0, 8'h00, st, sl);
        chk("prio_s4_sel", 32'(sl), 32'h10);
        chk("prio_s4_stall", 32'(st), 32'd1);
        access(16'h6800, 1'b0, 8'h00, st, sl);
        chk("s6_sel", 32'(sl), 32'h40);
        access(16'hF123, 1'b0, 8'h00, st, sl);
        chk("s7_sel", 32'(sl), 32'h80);
        chk("s7_stall", 32'(st), 32'd5);

        // Timeout on a slave that never becomes ready
        slv_rdy = 8'hFD;
        access(16'h1000, 1'b0, 8'h00, st, sl);
        slv_rdy = 8'hFF;
        chk("to_sel", 32'(sl), 32'h02);
        chk("to_stall", 32'(st), 32'd254);
        access(16'hF702, 1'b0, 8'h00, st, sl);
        chk("to_err", 32'(cpu_di), 32'h02);
        access(16'hF703, 1'b0, 8'h00, st, sl);
        chk("to_idx", 32'(cpu_di), 32'h01);
        access(16'hF702, 1'b1, 8'h02, st, sl);
        access(16'hF702, 1'b0, 8'h00, st, sl);
        chk("to_err_clr", 32'(cpu_di), 32'h00);

        // Interrupt masking
        slv_irq = 8'h81;
        #1;
        chk("irq_resetmask", 32'(cpu_irq), 32'd1);
        access(16'hF700, 1'b1, 8'h01, st, sl);
        chk("irq_mask01", 32'(cpu_irq), 32'd1);
        access(16'hF701, 1'b0, 8'h00, st, sl);
        chk("irq_pend", 32'(cpu_di), 32'h01);
        access(16'hF700, 1'b1, 8'h00, st, sl);
        chk("irq_masked", 32'(cpu_irq), 32'd0);
        access(16'hF700, 1'b0, 8'h00, st, sl);
        chk("irq_mask_rd", 32'(cpu_di), 32'h00);

        // Randomized reads against the reference model
        m_err  = 2'b00;
        m_idx  = 3'd1;
        m_mask = 8'($urandom());
        access(16'hF700, 1'b1, m_mask, st, sl);
        slv_irq = 8'($urandom());
        for (int it = 0; it < 48; it++) begin
            logic [15:0] a;
            int          s;
            int          exp_st;
            logic [7:0]  exp_sel;
            logic [7:0]  exp_d;
            a = 16'($urandom_range(0, 65535));
            if (it % 8 == 7) a = 16'hF700 + 16'($urandom_range(0, 3));
            slv_do = {$urandom(), $urandom()};
            s = ref_slot(a);
            if (s >= 0) begin
                exp_sel = 8'(1 << s);
                exp_st  = WT[s];
                exp_d   = slv_do[s*8 +: 8];
            end else begin
                exp_sel = 8'h00;
                exp_st  = 0;
                exp_d   = (s == -1) ? 8'hFF : ref_ctl(a[1:0]);
            end
            access(a, 1'b0, 8'h00, st, sl);
            chk("rnd_sel", 32'(sl), 32'(exp_sel));
            chk("rnd_stall", 32'(st), 32'(exp_st));
            chk("rnd_data", 32'(cpu_di), 32'(exp_d));
            if (s == -1) m_err[0] = 1'b1;
        end
        access(16'hF702, 1'b0, 8'h00, st, sl);
        chk("rnd_err", 32'(cpu_di), 32'({6'b0, m_err}));

        // Reset in the middle of a seven-cycle stall
        cpu_ab = 16'h3000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s3_pre_rst", 32'(cpu_rdy), 32'd0);
        end
        @(posedge clk);
        #1;
        reset  = 1'b1;
        cpu_ab = 16'h0000;
        @(negedge clk);
        chk("rst_mid_rdy", 32'(cpu_rdy), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 32'(cpu_rdy), 32'd1);
        @(posedge clk);
        #1;
        access(16'hF700, 1'b0, 8'h00, st, sl);
        chk("post_rst_mask", 32'(cpu_di), 32'hFF);
        access(16'hF702, 1'b0, 8'h00, st, sl);
        chk("post_rst_err", 32'(cpu_di), 32'h00);
        access(16'hF703, 1'b0, 8'h00, st, sl);
        chk("post_rst_idx", 32'(cpu_di), 32'h00);
        access(16'h3000, 1'b0, 8'h00, st, sl);
        chk("post_rst_s3_stall", 32'(st), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_fabric.md
CPU_BUS_FABRIC -- requirements
Module: cpu_bus_fabric

Interface
REQ-001 SHALL have parameter NSLV, default 8, number of slave ports (1..8).
REQ-002 SHALL have parameter AW, default 16, CPU address width.
REQ-003 SHALL have parameter DW, default 8, CPU data width.
REQ-004 SHALL have parameter SLV_BASE, default 0, packed NSLV*AW slave base addresses (slot i at [i*AW +: AW]).
REQ-005 SHALL have parameter SLV_MASK, default 0, packed NSLV*AW slave decode masks.
REQ-006 SHALL have parameter SLV_WAIT, default 0, packed NSLV*3 per-slave wait states (0..7).
REQ-007 SHALL have parameter CTL_BASE, default 16'hF700, and CTL_MASK, default 16'hFFFC, fabric control region.
REQ-008 SHALL have parameter TO_CYC, default 255, bus timeout in stall cycles (8-bit).
REQ-009 SHALL have parameter DEF_DATA, default 8'hFF, read data for unmapped addresses.
REQ-010 SHALL have ports: clk in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-011 SHALL have ports: cpu_ab in AW address; cpu_we in 1 write enable; cpu_do in DW CPU write data.
REQ-012 SHALL have ports: cpu_di out DW CPU read data; cpu_rdy out 1 CPU ready; cpu_irq out 1 combined interrupt.
REQ-013 SHALL have ports: slv_sel out NSLV one-hot select; slv_rdy in NSLV per-slave ready; slv_do in NSLV*DW slave read data; slv_irq in NSLV slave interrupts.

Function
REQ-014 Decode SHALL be combinational: slot i hits when (cpu_ab & MASK_i) == BASE_i; control region takes priority, then lowest i; slv_sel one-hot or zero.
REQ-015 No hit and no control hit = unmapped: slv_sel=0, no stall, read returns DEF_DATA, ERR[0] sets.
REQ-016 Register rdy_q (reset 1) holds previous cpu_rdy; an access is fresh when rdy_q=1.
REQ-017 Fresh access to slot i with WAIT_i=n>0: cpu_rdy=0, ws_cnt loads n-1; while ws_cnt!=0 cpu_rdy=0 and ws_cnt decrements; at ws_cnt=0 cpu_rdy=slv_rdy[i]; total stall exactly n cycles when slv_rdy held high.
REQ-018 WAIT_i=0: cpu_rdy=slv_rdy[i] combinationally; control and unmapped accesses never stall.
REQ-019 Read mux select (slot index, ctl flag, unmapped flag) SHALL register on clk only when cpu_rdy=1; cpu_di SHALL be driven from registered select, giving one-cycle read latency matched to synchronous slave RAMs.
REQ-020 Timeout counter SHALL count consecutive cpu_rdy=0 cycles; on reaching TO_CYC, cpu_rdy forced 1 for one cycle, ERR[1] sets, ERRIDX latches slot index, counter clears; counter clears whenever cpu_rdy=1.
REQ-021 Control registers (cpu_ab[1:0]): 0 IRQMASK RW, reset all ones; 1 IRQPEND RO = slv_irq & IRQMASK; 2 ERR W1C {bit1 timeout, bit0 unmapped}; 3 ERRIDX RO; control reads registered one cycle like slaves.
REQ-022 cpu_irq SHALL equal |(slv_irq & IRQMASK), combinational.
REQ-023 ERR write-1-clear coincident with a new set event of the same bit SHALL leave the bit set.
REQ-024 Writes SHALL reach slaves only via slv_sel plus CPU's cpu_we; fabric SHALL NOT register write data.

Reset
REQ-025 On reset assertion (async): rdy_q=1, ws_cnt=0, timeout counter=0, registered select=unmapped, IRQMASK=all ones, ERR=0, ERRIDX=0; cpu_rdy follows decode immediately after release.
REQ-026 Reset mid-stall SHALL abort the stall; first post-reset access is fresh.

Verification
REQ-027 Read slot 0 (WAIT=0, slv_rdy=1, slv_do=8'h5A) -> slv_sel=1, cpu_rdy=1, cpu_di=8'h5A next cycle.
REQ-028 Read slot 2 with WAIT=3 -> cpu_rdy low exactly 3 cycles, then high; mux select captured only on ready cycle.
REQ-029 slv_rdy[1] held 0, TO_CYC=255 -> cpu_rdy high on stall cycle 255, ERR=2'b10, ERRIDX=1; write 8'h02 to ERR -> ERR=0.
REQ-030 Read unmapped address -> cpu_rdy=1, cpu_di=8'hFF, ERR[0]=1.
REQ-031 slv_irq=8'h81, IRQMASK write 8'h01 -> cpu_irq=1, IRQPEND=8'h01; clear mask to 0 -> cpu_irq=0.
REQ-032 Assert reset during WAIT=7 stall -> cpu_rdy=1 after release, all counters zero, IRQMASK=8'hFF.
